// File: rtl/carregador_instrucoes_if.sv
// Byte-stream and instruction-memory write bus of the instruction loader.
// The loader sits on the slave side: it consumes bytes and drives the memory write port.
interface carregador_instrucoes_if;
  logic [7:0]  byte_dado;
  logic        byte_valido;
  logic        byte_ultimo;
  logic        byte_pronto;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_dado;

  modport master (
    output byte_dado, byte_valido, byte_ultimo,
    input  byte_pronto, mem_we, mem_addr, mem_dado
  );

  modport slave (
    input  byte_dado, byte_valido, byte_ultimo,
    output byte_pronto, mem_we, mem_addr, mem_dado
  );
endinterface

// File: rtl/carregador_instrucoes.sv
// Runtime instruction loader: packs a byte stream into big-endian 32-bit words and
// writes them one per pulse into the instruction memory, starting at BASE_END.
module carregador_instrucoes #(
  parameter int          PROF_PALAVRAS = 256,
  parameter logic [31:0] BASE_END      = 32'h00000000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             inicio,
  carregador_instrucoes_if.slave           bus,
  output logic                             ocupado,
  output logic                             concluido,
  output logic                             erro,
  output logic [$clog2(PROF_PALAVRAS):0]   palavras_escritas
);

  localparam logic [31:0] PROF = PROF_PALAVRAS[31:0];

  typedef enum logic [2:0] {OCIOSO, RECEBE, ESCREVE, FIM, ERRO} estado_t;

  estado_t     estado, prox;
  logic [1:0]  indice;
  logic [23:0] parcial;
  logic        ultimo_reg;
  logic        ultima_vaga;

  // The word being written is the last slot the memory can hold; no address wrap.
  assign ultima_vaga = (32'(palavras_escritas) + 32'd1) == PROF;

  always_ff @(posedge clk) begin
    if (reset) estado <= OCIOSO;
    else       estado <= prox;
  end

  always_comb begin
    prox            = estado;
    bus.byte_pronto = 1'b0;
    bus.mem_we      = 1'b0;
    ocupado         = 1'b0;
    concluido       = (estado == FIM);
    erro            = (estado == ERRO);
    case (estado)
      OCIOSO, FIM, ERRO: begin
        if (inicio) prox = RECEBE;
      end
      RECEBE: begin
        bus.byte_pronto = 1'b1;
        ocupado         = 1'b1;
        if (bus.byte_valido) begin
          if (indice == 2'd3)      prox = ESCREVE;
          else if (bus.byte_ultimo) prox = ERRO;
        end
      end
      ESCREVE: begin
        bus.mem_we = 1'b1;
        ocupado    = 1'b1;
        if (ultimo_reg)       prox = FIM;
        else if (ultima_vaga) prox = ERRO;
        else                  prox = RECEBE;
      end
      default: prox = OCIOSO;
    endcase
  end

  // First three bytes shift into a holding register; the fourth completes the word
  // straight into mem_dado so the write port stays stable outside the write cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      indice            <= 2'd0;
      parcial           <= 24'd0;
      ultimo_reg        <= 1'b0;
      palavras_escritas <= '0;
      bus.mem_addr      <= BASE_END;
      bus.mem_dado      <= 32'd0;
    end else begin
      case (estado)
        OCIOSO, FIM, ERRO: begin
          if (inicio) begin
            indice            <= 2'd0;
            ultimo_reg        <= 1'b0;
            palavras_escritas <= '0;
          end
        end
        RECEBE: begin
          if (bus.byte_valido) begin
            parcial <= {parcial[15:0], bus.byte_dado};
            indice  <= indice + 2'd1;
            if (indice == 2'd3) begin
              bus.mem_dado <= {parcial, bus.byte_dado};
              bus.mem_addr <= BASE_END + (32'(palavras_escritas) << 2);
              ultimo_reg   <= bus.byte_ultimo;
            end
          end
        end
        ESCREVE: begin
          palavras_escritas <= palavras_escritas + 1'b1;
          indice            <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_instrucoes.sv
// Directed bench for the instruction loader: two instances, a full-size one and a
// four-word one used to exercise the memory-full abort.
module tb_carregador_instrucoes;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inicio_a = 1'b0;
  logic       inicio_b = 1'b0;
  logic [7:0] byte_dado = 8'd0;
  logic       byte_valido = 1'b0;
  logic       byte_ultimo = 1'b0;
  bit         sel_b = 1'b0;

  logic       ocupado_a, concluido_a, erro_a;
  logic       ocupado_b, concluido_b, erro_b;
  logic [8:0] palavras_a;
  logic [2:0] palavras_b;

  int n_checks = 0;
  int n_errors = 0;
  int viol = 0;

  logic [31:0] qa_addr[$];
  logic [31:0] qa_dado[$];
  logic [31:0] qb_addr[$];
  logic [31:0] qb_dado[$];

  carregador_instrucoes_if bus_a();
  carregador_instrucoes_if bus_b();

  assign bus_a.byte_dado   = byte_dado;
  assign bus_a.byte_valido = byte_valido;
  assign bus_a.byte_ultimo = byte_ultimo;
  assign bus_b.byte_dado   = byte_dado;
  assign bus_b.byte_valido = byte_valido;
  assign bus_b.byte_ultimo = byte_ultimo;

  carregador_instrucoes #(.PROF_PALAVRAS(256), .BASE_END(32'h0)) dut_a (
    .clk(clk), .reset(reset), .inicio(inicio_a), .bus(bus_a.slave),
    .ocupado(ocupado_a), .concluido(concluido_a), .erro(erro_a),
    .palavras_escritas(palavras_a)
  );

  carregador_instrucoes #(.PROF_PALAVRAS(4), .BASE_END(32'h0)) dut_b (
    .clk(clk), .reset(reset), .inicio(inicio_b), .bus(bus_b.slave),
    .ocupado(ocupado_b), .concluido(concluido_b), .erro(erro_b),
    .palavras_escritas(palavras_b)
  );

  always #5 clk = ~clk;

  // Log every write pulse and watch that byte_pronto drops only in write cycles.
  always @(negedge clk) begin
    if (bus_a.mem_we) begin
      qa_addr.push_back(bus_a.mem_addr);
      qa_dado.push_back(bus_a.mem_dado);
    end
    if (bus_b.mem_we) begin
      qb_addr.push_back(bus_b.mem_addr);
      qb_dado.push_back(bus_b.mem_dado);
    end
    if (ocupado_a ? (bus_a.byte_pronto == bus_a.mem_we) : bus_a.byte_pronto) viol++;
    if (ocupado_b ? (bus_b.byte_pronto == bus_b.mem_we) : bus_b.byte_pronto) viol++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic startLoad(input bit on_b);
    if (on_b) inicio_b = 1'b1;
    else      inicio_a = 1'b1;
    waitCycles(1);
    inicio_a = 1'b0;
    inicio_b = 1'b0;
  endtask

  // Present one byte after some idle cycles; returns whether it was taken within budget.
  task automatic applyStimulus(input logic [7:0] b, input logic ult, input int gaps,
                               input int budget, output bit accepted);
    int n;
    bit ok;
    byte_valido = 1'b0;
    waitCycles(gaps);
    byte_dado   = b;
    byte_ultimo = ult;
    byte_valido = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      ok = sel_b ? bus_b.byte_pronto : bus_a.byte_pronto;
      @(posedge clk);
      #1;
      n++;
    end
    byte_valido = 1'b0;
    byte_ultimo = 1'b0;
    accepted = ok;
  endtask

  task automatic sendWord(input logic [31:0] w, input logic ult, input bit gaps_on);
    bit acc;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(w[31-8*i -: 8], ult && (i == 3),
                    gaps_on ? int'($urandom_range(0, 2)) : 0, 20, acc);
      checkOutput("byte accepted", 32'(acc), 32'd1);
    end
  endtask

  task automatic clearLogs();
    qa_addr.delete();
    qa_dado.delete();
    qb_addr.delete();
    qb_dado.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " byte_pronto"}, 32'(bus_a.byte_pronto), 32'd0);
    checkOutput({tag, " mem_we"},      32'(bus_a.mem_we),      32'd0);
    checkOutput({tag, " ocupado"},     32'(ocupado_a),         32'd0);
    checkOutput({tag, " concluido"},   32'(concluido_a),       32'd0);
    checkOutput({tag, " erro"},        32'(erro_a),            32'd0);
    checkOutput({tag, " mem_addr"},    bus_a.mem_addr,         32'h0);
    checkOutput({tag, " mem_dado"},    bus_a.mem_dado,         32'h0);
    checkOutput({tag, " palavras"},    32'(palavras_a),        32'd0);
  endtask

  logic [31:0] prog[4] = '{32'h20080001, 32'h20090002, 32'h01095020, 32'hAC0A0000};
  logic [31:0] ovf[5]  = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};

  initial begin
    bit acc;

    waitCycles(2);
    @(negedge clk);
    checkResetValues("reset");
    checkOutput("reset b erro", 32'(erro_b), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] basic load");
    clearLogs();
    startLoad(1'b0);
    for (int i = 0; i < 4; i++) sendWord(prog[i], i == 3, 1'b0);
    waitCycles(2);
    checkOutput("basic writes", 32'(qa_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < qa_addr.size(); i++) begin
      checkOutput("basic addr", qa_addr[i], 32'(i * 4));
      checkOutput("basic data", qa_dado[i], prog[i]);
    end
    checkOutput("basic concluido", 32'(concluido_a), 32'd1);
    checkOutput("basic erro",      32'(erro_a),      32'd0);
    checkOutput("basic palavras",  32'(palavras_a),  32'd4);
    checkOutput("basic ocupado",   32'(ocupado_a),   32'd0);

    $display("[TB] backpressure and gaps");
    clearLogs();
    startLoad(1'b0);
    for (int i = 0; i < 4; i++) sendWord(prog[i], i == 3, 1'b1);
    waitCycles(2);
    checkOutput("gaps writes", 32'(qa_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < qa_addr.size(); i++) begin
      checkOutput("gaps addr", qa_addr[i], 32'(i * 4));
      checkOutput("gaps data", qa_dado[i], prog[i]);
    end
    checkOutput("gaps concluido", 32'(concluido_a), 32'd1);
    checkOutput("gaps palavras",  32'(palavras_a),  32'd4);
    checkOutput("gaps pronto rule", 32'(viol), 32'd0);

    $display("[TB] partial word");
    clearLogs();
    startLoad(1'b0);
    applyStimulus(8'h12, 1'b0, 0, 20, acc);
    checkOutput("partial byte0", 32'(acc), 32'd1);
    applyStimulus(8'h34, 1'b1, 0, 20, acc);
    checkOutput("partial byte1", 32'(acc), 32'd1);
    waitCycles(2);
    checkOutput("partial writes",    32'(qa_addr.size()), 32'd0);
    checkOutput("partial erro",      32'(erro_a),         32'd1);
    checkOutput("partial concluido", 32'(concluido_a),    32'd0);
    checkOutput("partial palavras",  32'(palavras_a),     32'd0);

    $display("[TB] overflow on 4-word memory");
    clearLogs();
    sel_b = 1'b1;
    startLoad(1'b1);
    for (int i = 0; i < 4; i++) sendWord(ovf[i], 1'b0, 1'b0);
    waitCycles(2);
    applyStimulus(ovf[4][31:24], 1'b0, 0, 5, acc);
    checkOutput("ovf 5th byte refused", 32'(acc), 32'd0);
    waitCycles(2);
    checkOutput("ovf writes", 32'(qb_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < qb_addr.size(); i++) begin
      checkOutput("ovf addr", qb_addr[i], 32'(i * 4));
      checkOutput("ovf data", qb_dado[i], ovf[i]);
    end
    checkOutput("ovf erro",      32'(erro_b),      32'd1);
    checkOutput("ovf concluido", 32'(concluido_b), 32'd0);
    checkOutput("ovf palavras",  32'(palavras_b),  32'd4);
    checkOutput("ovf a idle",    32'(qa_addr.size()), 32'd0);
    sel_b = 1'b0;

    $display("[TB] reset mid-load");
    clearLogs();
    startLoad(1'b0);
    sendWord(32'h11223344, 1'b0, 1'b0);
    applyStimulus(8'h55, 1'b0, 0, 20, acc);
    applyStimulus(8'h66, 1'b0, 0, 20, acc);
    checkOutput("midload byte6", 32'(acc), 32'd1);
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    @(negedge clk);
    checkResetValues("midload");
    checkOutput("midload writes", 32'(qa_addr.size()), 32'd1);
    @(posedge clk);
    #1;
    clearLogs();
    startLoad(1'b0);
    sendWord(32'hCAFEBABE, 1'b1, 1'b0);
    waitCycles(2);
    checkOutput("after reset writes", 32'(qa_addr.size()), 32'd1);
    if (qa_addr.size() > 0) begin
      checkOutput("after reset addr", qa_addr[0], 32'h0);
      checkOutput("after reset data", qa_dado[0], 32'hCAFEBABE);
    end
    checkOutput("after reset palavras",  32'(palavras_a),  32'd1);
    checkOutput("after reset concluido", 32'(concluido_a), 32'd1);

    $display("[TB] restart and ignore");
    clearLogs();
    startLoad(1'b0);
    applyStimulus(8'hDE, 1'b0, 0, 20, acc);
    applyStimulus(8'hAD, 1'b0, 0, 20, acc);
    startLoad(1'b0);
    applyStimulus(8'hBE, 1'b0, 0, 20, acc);
    applyStimulus(8'hEF, 1'b0, 0, 20, acc);
    sendWord(32'h01234567, 1'b1, 1'b0);
    waitCycles(2);
    checkOutput("ignore writes", 32'(qa_addr.size()), 32'd2);
    if (qa_addr.size() > 1) begin
      checkOutput("ignore addr0", qa_addr[0], 32'h0);
      checkOutput("ignore data0", qa_dado[0], 32'hDEADBEEF);
      checkOutput("ignore addr1", qa_addr[1], 32'h4);
      checkOutput("ignore data1", qa_dado[1], 32'h01234567);
    end
    checkOutput("ignore palavras",  32'(palavras_a),  32'd2);
    checkOutput("ignore concluido", 32'(concluido_a), 32'd1);
    clearLogs();
    startLoad(1'b0);
    @(negedge clk);
    checkOutput("restart concluido", 32'(concluido_a), 32'd0);
    checkOutput("restart palavras",  32'(palavras_a),  32'd0);
    checkOutput("restart ocupado",   32'(ocupado_a),   32'd1);
    @(posedge clk);
    #1;
    sendWord(32'h89ABCDEF, 1'b1, 1'b0);
    waitCycles(2);
    checkOutput("restart writes", 32'(qa_addr.size()), 32'd1);
    if (qa_addr.size() > 0) begin
      checkOutput("restart addr", qa_addr[0], 32'h0);
      checkOutput("restart data", qa_dado[0], 32'h89ABCDEF);
    end
    checkOutput("restart palavras end", 32'(palavras_a), 32'd1);
    checkOutput("pronto rule overall", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
